vedic8_seq_ctrl: RTL and testbench

VEDIC8_SEQ_CTRL -- requirements
Module: vedic8_seq_ctrl

---
 rtl/vedic8_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_vedic8_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vedic8_seq_ctrl.sv
// 8x8 unsigned multiplier time-sharing one 4x4 Vedic core over four cycles; result 4 cycles after acceptance.
// in_ready only in IDLE; product held in DONE until out_ready; flush aborts from any state.

module vedic2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    logic c1;
    assign p_o[0] = a_i[0] & b_i[0];
    assign p_o[1] = (a_i[1] & b_i[0]) ^ (a_i[0] & b_i[1]);
    assign c1     = (a_i[1] & b_i[0]) & (a_i[0] & b_i[1]);
    assign p_o[2] = (a_i[1] & b_i[1]) ^ c1;
    assign p_o[3] = (a_i[1] & b_i[1]) & c1;
endmodule

module vedic4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    logic [3:0] q0, q1, q2, q3;
    vedic2 u_ll (.a_i(a_i[1:0]), .b_i(b_i[1:0]), .p_o(q0));
    vedic2 u_hl (.a_i(a_i[3:2]), .b_i(b_i[1:0]), .p_o(q1));
    vedic2 u_lh (.a_i(a_i[1:0]), .b_i(b_i[3:2]), .p_o(q2));
    vedic2 u_hh (.a_i(a_i[3:2]), .b_i(b_i[3:2]), .p_o(q3));
    assign p_o = {4'h0, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'h0};
endmodule

module vedic8_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    input  logic        flush,
    output logic        busy,
    output logic [1:0]  step
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  step_q, step_d;
    logic [3:0]  nib_a, nib_b;
    logic [7:0]  pp;
    logic [15:0] pp_sh;
    logic        zero_op;

    // step[0] picks the high nibble of a, step[1] the high nibble of b
    assign nib_a = step_q[0] ? a_q[7:4] : a_q[3:0];
    assign nib_b = step_q[1] ? b_q[7:4] : b_q[3:0];

    vedic4 u_mul (.a_i(nib_a), .b_i(nib_b), .p_o(pp));

    always_comb begin
        pp_sh = {pp, 8'h00};
        case (step_q)
            2'd0:    pp_sh = {8'h00, pp};
            2'd1,
            2'd2:    pp_sh = {4'h0, pp, 4'h0};
            default: pp_sh = {pp, 8'h00};
        endcase
    end

    assign zero_op = SKIP_ZERO && ((a_q == 8'h00) || (b_q == 8'h00));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;
        if (flush) begin
            state_d = IDLE;
            acc_d   = 16'h0000;
            step_d  = 2'd0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 16'h0000;
                    step_d  = 2'd0;
                    state_d = MUL;
                end
                MUL: begin
                    // zero check runs on the captured operands in the first MUL cycle
                    if (zero_op && step_q == 2'd0) begin
                        acc_d   = 16'h0000;
                        state_d = DONE;
                    end else begin
                        acc_d = acc_q + pp_sh;
                        if (step_q == 2'd3) begin
                            step_d  = 2'd0;
                            state_d = DONE;
                        end else begin
                            step_d = step_q + 2'd1;
                        end
                    end
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc_q   <= 16'h0000;
            step_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL) || (state_q == DONE);
    assign step      = (state_q == MUL) ? step_q : 2'd0;
    assign p         = (state_q == DONE) ? acc_q : 16'h0000;
endmodule

// File: tb/tb_vedic8_seq_ctrl.sv
// Directed bench for vedic8_seq_ctrl: handshake timing, backpressure, skip path, reset/flush abort, product sweep.
module tb_vedic8_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, flush;
    logic [7:0]  a, b;
    logic        in_ready, out_valid, busy;
    logic [15:0] p;
    logic [1:0]  step;
    logic        z_in_ready, z_out_valid, z_busy;
    logic [15:0] z_p;
    logic [1:0]  z_step;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    vedic8_seq_ctrl #(.SKIP_ZERO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p),
        .flush(flush), .busy(busy), .step(step));

    vedic8_seq_ctrl #(.SKIP_ZERO(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
        .a(a), .b(b), .out_valid(z_out_valid), .out_ready(out_ready), .p(z_p),
        .flush(flush), .busy(z_busy), .step(z_step));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int        hs;
        int        nprod;
        logic      seen;
        logic      got;
        logic [7:0] sa, sb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; a = 8'h00; b = 8'h00;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_p", p, 0);
        chk("rst_step", step, 0);
        tick();
        rst_n = 1'b1;

        // full-scale product, out_ready held high
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
        tick();
        in_valid = 1'b0;
        chk("ff_e0_step", step, 0);
        chk("ff_e0_busy", busy, 1);
        chk("ff_e0_in_ready", in_ready, 0);
        chk("ff_e0_p_hidden", p, 0);
        tick(); chk("ff_e1_step", step, 1);
        tick(); chk("ff_e2_step", step, 2);
        tick(); chk("ff_e3_step", step, 3);
        chk("ff_e3_out_valid", out_valid, 0);
        tick();
        chk("ff_e4_out_valid", out_valid, 1);
        chk("ff_e4_p", p, 16'hFE01);
        chk("ff_e4_step", step, 0);
        tick();
        chk("ff_e5_in_ready", in_ready, 1);
        chk("ff_e5_out_valid", out_valid, 0);

        // backpressure in DONE, operand changes during MUL
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h3C; b = 8'hA5;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 8'(i * 37 + 1); b = 8'(i * 91 + 7);
            tick();
        end
        tick();
        chk("bp_e4_out_valid", out_valid, 1);
        chk("bp_e4_p", p, 16'h26AC);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_p", p, 16'h26AC);
            chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel_in_ready", in_ready, 1);
        chk("bp_rel_out_valid", out_valid, 0);
        chk("bp_rel_busy", busy, 0);
        in_valid = 1'b0;

        // zero operand: skip path vs full sequence
        in_valid = 1'b1; a = 8'h00; b = 8'h7E;
        tick();
        in_valid = 1'b0;
        chk("zs_e0_valid", z_out_valid, 0);
        chk("zs_e0_busy", z_busy, 1);
        tick();
        chk("zs_e1_valid", z_out_valid, 1);
        chk("zs_e1_p", z_p, 0);
        chk("z0_e1_valid", out_valid, 0);
        chk("z0_e1_step", step, 1);
        tick();
        chk("zs_e2_in_ready", z_in_ready, 1);
        tick();
        chk("z0_e3_valid", out_valid, 0);
        tick();
        chk("z0_e4_valid", out_valid, 1);
        chk("z0_e4_p", p, 0);
        tick();
        chk("z0_e5_in_ready", in_ready, 1);

        // async reset at step 2
        in_valid = 1'b1; a = 8'h55; b = 8'h66;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("rs_step2", step, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async_busy", busy, 0);
        chk("rs_async_step", step, 0);
        chk("rs_async_in_ready", in_ready, 1);
        chk("rs_async_p", p, 0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | out_valid;
        end
        chk("rs_no_valid", seen, 0);
        in_valid = 1'b1; a = 8'h12; b = 8'h34;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("rs_next_valid", out_valid, 1);
        chk("rs_next_p", p, 16'h03A8);
        tick();

        // flush at step 1 with in_valid high
        in_valid = 1'b1; a = 8'h77; b = 8'h99;
        tick();
        in_valid = 1'b0;
        tick();
        chk("fl_step1", step, 1);
        flush = 1'b1; in_valid = 1'b1;
        tick();
        chk("fl_idle_in_ready", in_ready, 1);
        chk("fl_idle_busy", busy, 0);
        chk("fl_idle_step", step, 0);
        tick();
        chk("fl_idle_no_accept", busy, 0);
        flush = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | out_valid;
        end
        chk("fl_no_valid", seen, 0);
        in_valid = 1'b1; a = 8'h80; b = 8'h02;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("fl_next_valid", out_valid, 1);
        chk("fl_next_p", p, 16'h0100);
        tick();

        // operand sweep with random backpressure
        hs = 0;
        nprod = 1200;
        for (int n = 0; n < nprod; n++) begin
            case (n)
                0:       begin sa = 8'h00; sb = 8'h00; end
                1:       begin sa = 8'hFF; sb = 8'h01; end
                2:       begin sa = 8'h01; sb = 8'hFF; end
                3:       begin sa = 8'h0F; sb = 8'hF0; end
                4:       begin sa = 8'hF0; sb = 8'h0F; end
                default: begin sa = 8'($urandom_range(0, 255)); sb = 8'($urandom_range(0, 255)); end
            endcase
            chk("sw_in_ready", in_ready, 1);
            in_valid = 1'b1; a = sa; b = sb;
            tick();
            in_valid = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    chk("sw_p", p, 32'(sa) * 32'(sb));
                    hs++;
                    got = 1'b1;
                end
                tick();
            end
            if (!got) chk("sw_timeout", 0, 1);
            chk("sw_post_valid", out_valid, 0);
        end
        chk("sw_handshakes", hs, nprod);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
